// File: rtl/diff_enc_ser.sv
// diff_enc_ser: differential encoder + LSB-first bit serializer
// AXI-Stream words in, one encoded bit per beat out (BPSK tx path)
module diff_enc_ser #(
  parameter int   C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int   C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int   PREAMBLE_LEN           = 8,
  parameter logic INIT_REF               = 1'b0
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

  localparam int BW = $clog2(C_S00_AXIS_TDATA_WIDTH);
  localparam int PW =
    (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam int PMAX =
    (PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0;

  localparam logic [BW-1:0] BIT_LAST =
    BW'(C_S00_AXIS_TDATA_WIDTH - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PMAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRE    = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_STARVE = 2'd3;

  localparam logic [1:0] S_START =
    (PREAMBLE_LEN > 0) ? S_PRE : S_DATA;

  logic clk;
  logic rst;

  logic [1:0]                        state;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] word;
  logic                              held_last;
  logic [BW-1:0]                     bitcnt;
  logic [PW-1:0]                     pcnt;
  logic                              ref_bit;
  logic                              out_bit;
  logic                              out_last;
  logic                              out_valid;

  logic bit_avail;
  logic advance;
  logic last_bit;
  logic raw;
  logic s_hs;
  logic unused_strb;

  assign clk = s00_axis_aclk;
  assign rst = s00_axis_aresetn;

  assign unused_strb = ^s00_axis_tstrb;

  assign bit_avail = (state == S_PRE) ||
                     (state == S_DATA);
  assign advance   = bit_avail &&
                     (!out_valid || m00_axis_tready);
  assign last_bit  = (bitcnt == BIT_LAST);
  assign raw       = (state == S_PRE) ? 1'b1
                                      : word[bitcnt];

  // word register frees up exactly as its final bit leaves
  assign s00_axis_tready =
    (state == S_IDLE) ||
    (state == S_STARVE) ||
    ((state == S_DATA) && last_bit && advance);

  assign s_hs = s00_axis_tvalid && s00_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word      <= '0;
      held_last <= 1'b0;
      bitcnt    <= '0;
      pcnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_hs) begin
            word      <= s00_axis_tdata;
            held_last <= s00_axis_tlast;
            bitcnt    <= '0;
            pcnt      <= '0;
            state     <= S_START;
          end
        end
        S_PRE: begin
          if (advance) begin
            if (pcnt == PRE_LAST) begin
              state <= S_DATA;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
        end
        S_DATA: begin
          if (advance) begin
            if (last_bit) begin
              bitcnt <= '0;
              if (s_hs) begin
                word      <= s00_axis_tdata;
                held_last <= s00_axis_tlast;
                pcnt      <= '0;
                state     <= held_last ? S_START
                                       : S_DATA;
              end else begin
                state <= held_last ? S_IDLE
                                   : S_STARVE;
              end
            end else begin
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        S_STARVE: begin
          // resume mid-packet: no preamble
          if (s_hs) begin
            word      <= s00_axis_tdata;
            held_last <= s00_axis_tlast;
            bitcnt    <= '0;
            state     <= S_DATA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_bit   <= INIT_REF;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      out_bit   <= ref_bit ^ raw;
      ref_bit   <= ref_bit ^ raw;
      out_last  <= (state == S_DATA) &&
                   last_bit && held_last;
      out_valid <= 1'b1;
    end else if (m00_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign m00_axis_tvalid = out_valid;
  assign m00_axis_tlast  = out_last;
  assign m00_axis_tdata  =
    C_M00_AXIS_TDATA_WIDTH'(out_bit);
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_diff_enc_ser.sv
// tb_diff_enc_ser: directed + random checks for diff_enc_ser
// dut_a has an 8-bit preamble, dut_b has none
module tb_diff_enc_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_last;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic        m_ready;

  logic        s_ready_a, m_valid_a, m_last_a;
  logic [31:0] m_data_a;
  logic [3:0]  m_strb_a;
  logic        s_ready_b, m_valid_b, m_last_b;
  logic [31:0] m_data_b;
  logic [3:0]  m_strb_b;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  always #5 clk = ~clk;

  diff_enc_ser #(.PREAMBLE_LEN(8)) dut_a (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst),
    .s00_axis_tvalid (s_valid),
    .s00_axis_tlast  (s_last),
    .s00_axis_tdata  (s_data),
    .s00_axis_tstrb  (s_strb),
    .s00_axis_tready (s_ready_a),
    .m00_axis_tready (m_ready),
    .m00_axis_tvalid (m_valid_a),
    .m00_axis_tlast  (m_last_a),
    .m00_axis_tdata  (m_data_a),
    .m00_axis_tstrb  (m_strb_a)
  );

  diff_enc_ser #(.PREAMBLE_LEN(0)) dut_b (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst),
    .s00_axis_tvalid (s_valid),
    .s00_axis_tlast  (s_last),
    .s00_axis_tdata  (s_data),
    .s00_axis_tstrb  (s_strb),
    .s00_axis_tready (s_ready_b),
    .m00_axis_tready (m_ready),
    .m00_axis_tvalid (m_valid_b),
    .m00_axis_tlast  (m_last_b),
    .m00_axis_tdata  (m_data_b),
    .m00_axis_tstrb  (m_strb_b)
  );

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // drive one cycle's inputs, sample outputs before next posedge
  task automatic cycle(
    input  logic        sv,
    input  logic [31:0] sd,
    input  logic        sl,
    input  logic        mr,
    output logic        sr,
    output logic        mv,
    output logic        b,
    output logic        l
  );
    @(negedge clk);
    s_valid = sv;
    s_data = sd;
    s_last = sl;
    m_ready = mr;
    #1;
    if (sel == 0) begin
      sr = s_ready_a; mv = m_valid_a;
      b = m_data_a[0]; l = m_last_a;
    end else begin
      sr = s_ready_b; mv = m_valid_b;
      b = m_data_b[0]; l = m_last_b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (m_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", m_valid_a);
    end
    do_reset();
    #1;
    checks++;
    if ({m_valid_a, m_last_a, m_data_a} !== 34'd0) begin
      errors++;
      $display("FAIL rst_out got %b %b %h want 0 0 0",
               m_valid_a, m_last_a, m_data_a);
    end
    checks++;
    if (s_ready_a !== 1'b1 || m_strb_a !== 4'hf) begin
      errors++;
      $display("FAIL rst_ready got %b %h want 1 f",
               s_ready_a, m_strb_a);
    end
  endtask

  // one packet of one word, m00 always ready
  task automatic one_word(
    input  logic [31:0] w,
    input  int          ncyc,
    output int          hs,
    output logic        bq[$],
    output logic        lq[$],
    output int          cq[$]
  );
    logic sv, sr, mv, b, l;
    hs = -1;
    bq = {}; lq = {}; cq = {};
    for (int c = 0; c < ncyc; c++) begin
      sv = (hs < 0);
      cycle(sv, w, 1'b1, 1'b1, sr, mv, b, l);
      if (sv && sr) hs = c;
      if (mv) begin
        bq.push_back(b); lq.push_back(l); cq.push_back(c);
      end
    end
  endtask

  task automatic test_preamble();
    int hs; logic bq[$]; logic lq[$]; int cq[$];
    logic e;
    sel = 0;
    do_reset();
    one_word(32'h0, 60, hs, bq, lq, cq);
    checks++;
    if (bq.size() != 40) begin
      errors++;
      $display("FAIL pre_count got %0d want 40", bq.size());
    end else begin
      checks++;
      if (cq[0] != hs + 2 || cq[39] - cq[0] != 39) begin
        errors++;
        $display("FAIL pre_timing got first %0d span %0d want %0d 39",
                 cq[0], cq[39] - cq[0], hs + 2);
      end
      for (int i = 0; i < 40; i++) begin
        e = (i < 8) && (i % 2 == 0);
        checks++;
        if ({bq[i], lq[i]} !== {e, (i == 39)}) begin
          errors++;
          $display("FAIL pre_beat%0d got %b%b want %b%b",
                   i, bq[i], lq[i], e, (i == 39));
        end
      end
    end
  endtask

  task automatic test_no_preamble();
    int hs; logic bq[$]; logic lq[$]; int cq[$];
    logic e;
    sel = 1;
    do_reset();
    one_word(32'hffff_ffff, 50, hs, bq, lq, cq);
    checks++;
    if (bq.size() != 32) begin
      errors++;
      $display("FAIL nopre_count got %0d want 32", bq.size());
    end else begin
      checks++;
      if (cq[0] != hs + 2) begin
        errors++;
        $display("FAIL nopre_latency got %0d want %0d",
                 cq[0], hs + 2);
      end
      for (int i = 0; i < 32; i++) begin
        e = (i % 2 == 0);
        checks++;
        if ({bq[i], lq[i]} !== {e, (i == 31)}) begin
          errors++;
          $display("FAIL nopre_beat%0d got %b%b want %b%b",
                   i, bq[i], lq[i], e, (i == 31));
        end
      end
      checks++;
      if (bq[31] !== 1'b0) begin
        errors++;
        $display("FAIL nopre_final_ref got %b want 0", bq[31]);
      end
    end
    sel = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1, wx;
    logic sv, sr, mv, b, l, prev, raw, e;
    logic bq[$]; logic lq[$]; int cq[$];
    int n, hs1, bad;
    w0 = 32'h0000_000b;
    w1 = 32'h8000_0000;
    n = 0; hs1 = -1;
    sel = 0;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      sv = (n < 2);
      wx = (n == 0) ? w0 : w1;
      cycle(sv, wx, (n != 0), 1'b1, sr, mv, b, l);
      if (sv && sr) begin
        if (n == 1) hs1 = c;
        n++;
      end
      if (mv) begin
        bq.push_back(b); lq.push_back(l); cq.push_back(c);
      end
    end
    checks++;
    if (bq.size() != 72) begin
      errors++;
      $display("FAIL b2b_count got %0d want 72", bq.size());
    end else begin
      checks++;
      if (cq[71] - cq[0] != 71) begin
        errors++;
        $display("FAIL b2b_gap got span %0d want 71",
                 cq[71] - cq[0]);
      end
      checks++;
      if (hs1 != cq[39] - 1) begin
        errors++;
        $display("FAIL b2b_ready_pulse got %0d want %0d",
                 hs1, cq[39] - 1);
      end
      prev = 1'b0; bad = 0;
      for (int i = 0; i < 72; i++) begin
        raw = prev ^ bq[i];
        prev = bq[i];
        if (i < 8) e = 1'b1;
        else if (i < 40) e = w0[i - 8];
        else e = w1[i - 40];
        checks++;
        if ({raw, lq[i]} !== {e, (i == 71)}) begin
          errors++;
          $display("FAIL b2b_dec%0d got %b%b want %b%b",
                   i, raw, lq[i], e, (i == 71));
        end
      end
    end
  endtask

  task automatic test_starve();
    logic [31:0] w1, w2;
    logic sv, sr, mv, b, l, prev, raw;
    logic bq[$]; logic lq[$];
    int hs, n1;
    w1 = 32'h1234_5678;
    w2 = 32'h0000_f00f;
    sel = 0;
    do_reset();
    hs = -1; n1 = 0;
    for (int c = 0; c < 60; c++) begin
      sv = (hs < 0);
      cycle(sv, w1, 1'b0, 1'b1, sr, mv, b, l);
      if (sv && sr) hs = c;
      if (mv) begin n1++; prev = b; end
    end
    checks++;
    if (n1 != 40 || mv !== 1'b0 || sr !== 1'b1) begin
      errors++;
      $display("FAIL starve_drain got %0d %b %b want 40 0 1",
               n1, mv, sr);
    end
    hs = -1;
    for (int c = 0; c < 50; c++) begin
      sv = (hs < 0);
      cycle(sv, w2, 1'b1, 1'b1, sr, mv, b, l);
      if (sv && sr) hs = c;
      if (mv) begin bq.push_back(b); lq.push_back(l); end
    end
    checks++;
    if (bq.size() != 32) begin
      errors++;
      $display("FAIL starve_resume_count got %0d want 32",
               bq.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        raw = prev ^ bq[i];
        prev = bq[i];
        checks++;
        if ({raw, lq[i]} !== {w2[i], (i == 31)}) begin
          errors++;
          $display("FAIL starve_dec%0d got %b%b want %b%b",
                   i, raw, lq[i], w2[i], (i == 31));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic sv, sr, mv, b, l, e;
    int hs, n;
    logic bq[$]; logic lq[$]; int cq[$];
    sel = 0;
    do_reset();
    hs = -1; n = 0;
    for (int c = 0; c < 60 && n < 20; c++) begin
      sv = (hs < 0);
      cycle(sv, 32'h1, 1'b1, 1'b1, sr, mv, b, l);
      if (sv && sr) hs = c;
      if (mv) n++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_valid_a, m_last_a, m_data_a} !== 34'd0) begin
      errors++;
      $display("FAIL midrst_async got %b %b %h want 0 0 0",
               m_valid_a, m_last_a, m_data_a);
    end
    @(negedge clk);
    rst = 1'b0;
    one_word(32'h0, 60, hs, bq, lq, cq);
    checks++;
    if (bq.size() != 40) begin
      errors++;
      $display("FAIL midrst_count got %0d want 40", bq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        e = (i < 8) && (i % 2 == 0);
        checks++;
        if (bq[i] !== e) begin
          errors++;
          $display("FAIL midrst_beat%0d got %b want %b",
                   i, bq[i], e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] wd[1000];
    logic        wl[1000];
    logic        er[$];
    logic        el[$];
    logic sv, mr, sr, mv, b, l, prev, raw;
    logic pend, pb, pl, start;
    logic [31:0] wx;
    int n, got, bad, sbad, c, first;
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wd[i] = $urandom;
      wl[i] = ($urandom_range(0, 15) == 0) || (i == 999);
      if (start)
        for (int k = 0; k < 8; k++) begin
          er.push_back(1'b1); el.push_back(1'b0);
        end
      for (int k = 0; k < 32; k++) begin
        er.push_back(wd[i][k]);
        el.push_back(wl[i] && (k == 31));
      end
      start = wl[i];
    end
    sel = 0;
    do_reset();
    n = 0; got = 0; bad = 0; sbad = 0; c = 0;
    first = -1; prev = 1'b0; pend = 1'b0;
    while ((n < 1000 || got < er.size() || c < 20) &&
           c < 95000) begin
      sv = (n < 1000);
      wx = sv ? wd[n] : 32'h0;
      mr = (n < 1000 || got < er.size())
           ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(sv, wx, sv ? wl[n] : 1'b0, mr, sr, mv, b, l);
      if (sv && sr) n++;
      if (pend && !(mv && b == pb && l == pl)) sbad++;
      pend = mv && !mr;
      pb = b; pl = l;
      if (mv && mr) begin
        raw = prev ^ b;
        prev = b;
        if (got >= er.size() ||
            {raw, l} !== {er[got], el[got]}) begin
          bad++;
          if (first < 0) first = got;
        end
        got++;
      end
      if (n == 1000 && got >= er.size()) c++;
      else if (c < 20) c = 0;
      if (c >= 20 && c < 95000 &&
          !(n < 1000 || got < er.size())) break;
    end
    checks++;
    if (n != 1000 || got != er.size()) begin
      errors++;
      $display("FAIL rnd_count got %0d words %0d beats want 1000 %0d",
               n, got, er.size());
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rnd_stream got %0d bad beats (first %0d) want 0",
               bad, first);
    end
    checks++;
    if (sbad != 0) begin
      errors++;
      $display("FAIL rnd_stall_hold got %0d changes want 0", sbad);
    end
  endtask

  initial begin
    s_strb = 4'hf;
    test_reset();
    test_preamble();
    test_no_preamble();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
